// File: rtl/two_3_pkg.sv
// Shared definitions for the two_3 multiplier family: operand widths and
// the dot-product FSM state encoding.
package two_3_pkg;

  localparam int M_W = 2;
  localparam int Q_W = 3;
  localparam int P_W = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/two_3_dot_product_if.sv
// Streaming operand/result bundle for two_3_dot_product, plus FSM debug view.
interface two_3_dot_product_if
  import two_3_pkg::*;
#(
  parameter int ACC_WIDTH = 8
) ();

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and its payload steady until it transfers,
  // and ready never depends combinationally on valid.
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [M_W-1:0]       m;
  logic [Q_W-1:0]       q;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_overflow;
  logic                 busy;
  state_e               dbg_state;

  modport master (
    output clear, in_valid, m, q, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, busy, dbg_state
  );

  modport slave (
    input  clear, in_valid, m, q, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, busy, dbg_state
  );

endinterface

// File: rtl/two_3_multiplier.sv
// Combinational 2-bit x 3-bit unsigned multiplier.
module two_3_multiplier
  import two_3_pkg::*;
(
  input  logic [M_W-1:0] m,
  input  logic [Q_W-1:0] q,
  output logic [P_W-1:0] p
);

  assign p = P_W'(m) * P_W'(q);

endmodule

// File: rtl/two_3_dot_product.sv
// Streaming saturating multiply-accumulate: sums LENGTH products of the
// wrapped two_3_multiplier and offers each result on a valid/ready port.
module two_3_dot_product
  import two_3_pkg::*;
#(
  parameter int LENGTH    = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic clock,
  input  logic reset_n,
  two_3_dot_product_if.slave bus
);

  localparam int                   CNT_W   = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(LENGTH - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 oflow_q, oflow_d;
  logic                 valid_q, valid_d;

  logic [P_W-1:0]       p;
  logic [ACC_WIDTH:0]   acc_ext;
  logic                 clip;
  logic [ACC_WIDTH-1:0] acc_sat;

  two_3_multiplier u_mult (
    .m (bus.m),
    .q (bus.q),
    .p (p)
  );

  // One guard bit is enough: max accumulator plus max product never reaches 2^(W+1).
  assign acc_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - P_W){1'b0}}, p};
  assign clip    = acc_ext[ACC_WIDTH];
  assign acc_sat = clip ? ACC_MAX : acc_ext[ACC_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      oflow_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      oflow_q <= oflow_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    oflow_d = oflow_q;
    valid_d = valid_q;
    if (bus.clear) begin
      // Abort drops the partial sum and any pending result; out_sum keeps its last value.
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            if (count_q == LAST) begin
              sum_d   = acc_sat;
              oflow_d = ovf_q | clip;
              valid_d = 1'b1;
              acc_d   = '0;
              count_d = '0;
              ovf_d   = 1'b0;
              state_d = HOLD;
            end else begin
              acc_d   = acc_sat;
              count_d = count_q + CNT_W'(1);
              ovf_d   = ovf_q | clip;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_d = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == ACCUM);
  assign bus.out_valid    = valid_q;
  assign bus.out_sum      = sum_q;
  assign bus.out_overflow = oflow_q;
  assign bus.busy         = (count_q != '0);
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_two_3_dot_product.sv
// Bench for two_3_dot_product: directed vector table, async reset, input gaps,
// LENGTH=1 corner and randomized traffic against a product-list reference model.
module tb_two_3_dot_product;
  import two_3_pkg::*;

  localparam int LEN = 4;
  localparam int AW  = 6;
  localparam int SAT = (1 << AW) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  two_3_dot_product_if #(.ACC_WIDTH(AW)) bus ();
  two_3_dot_product_if #(.ACC_WIDTH(5))  bus1 ();

  two_3_dot_product #(.LENGTH(LEN), .ACC_WIDTH(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  two_3_dot_product #(.LENGTH(1), .ACC_WIDTH(5)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: products accepted toward the current result, a hold flag
  // and a scoreboard of {overflow, sum} results awaiting handshake.
  int            prods[$];
  bit            hold;
  logic [AW:0]   exp_q[$];

  typedef struct {
    bit clr;
    bit iv;
    int m;
    int q;
    bit ordy;
    bit e_rdy;
    bit e_vld;
    bit e_busy;
    int e_sum;   // -1: result not checked on this row
    bit e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    prods.delete();
    hold = 1'b0;
    exp_q.delete();
  endtask

  // Check outputs against the model, apply one cycle of inputs, advance the model.
  task automatic do_cycle(input bit clr, input bit iv, input int mm, input int qq, input bit ordy);
    chk("model_in_ready", int'(bus.in_ready), int'(!hold));
    chk("model_out_valid", int'(bus.out_valid), int'(hold));
    chk("model_busy", int'(bus.busy), int'(prods.size() != 0));
    if (hold && exp_q.size() > 0) begin
      chk("model_out_sum", int'(bus.out_sum), int'(exp_q[0][AW-1:0]));
      chk("model_out_overflow", int'(bus.out_overflow), int'(exp_q[0][AW]));
    end
    bus.clear     = clr;
    bus.in_valid  = iv;
    bus.m         = mm[1:0];
    bus.q         = qq[2:0];
    bus.out_ready = ordy;
    if (clr) begin
      if (hold) void'(exp_q.pop_front());
      hold = 1'b0;
      prods.delete();
    end else if (hold) begin
      if (ordy) begin
        void'(exp_q.pop_front());
        hold = 1'b0;
      end
    end else if (iv) begin
      prods.push_back(mm * qq);
      if (prods.size() == LEN) begin
        int s;
        logic [AW:0] e;
        s = 0;
        foreach (prods[k]) s += prods[k];
        e[AW]        = (s > SAT);
        e[AW-1:0]    = (s > SAT) ? AW'(SAT) : AW'(s);
        exp_q.push_back(e);
        hold = 1'b1;
        prods.delete();
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic add(input bit clr, input bit iv, input int mm, input int qq, input bit ordy,
                     input bit rdy, input bit vld, input bit bsy, input int sum, input bit ovf);
    vec_t v;
    v.clr = clr; v.iv = iv; v.m = mm; v.q = qq; v.ordy = ordy;
    v.e_rdy = rdy; v.e_vld = vld; v.e_busy = bsy; v.e_sum = sum; v.e_ovf = ovf;
    tbl.push_back(v);
  endtask

  initial begin
    int gm[4];
    int gq[4];
    gm = '{1, 3, 1, 2};
    gq = '{1, 3, 5, 4};

    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.m = '0; bus.q = '0; bus.out_ready = 1'b0;
    bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.m = '0; bus1.q = '0; bus1.out_ready = 1'b0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_sum", int'(bus.out_sum), 0);
    chk("reset_out_overflow", int'(bus.out_overflow), 0);
    chk("reset_busy", int'(bus.busy), 0);
    reset_n = 1'b1;

    // Basic dot product 1*1+3*3+1*5+2*4 = 23 with out_ready high.
    add(0,1,1,1,1, 1,0,1, -1,0);
    add(0,1,3,3,1, 1,0,1, -1,0);
    add(0,1,1,5,1, 1,0,1, -1,0);
    add(0,1,2,4,1, 0,1,0, 23,0);
    add(0,0,0,0,1, 1,0,0, -1,0);
    // Backpressure: five held cycles with a (3,7) pair offered throughout.
    add(0,1,1,1,0, 1,0,1, -1,0);
    add(0,1,3,3,0, 1,0,1, -1,0);
    add(0,1,1,5,0, 1,0,1, -1,0);
    add(0,1,2,4,0, 0,1,0, 23,0);
    for (int i = 0; i < 5; i++) add(0,1,3,7,0, 0,1,0, 23,0);
    add(0,1,3,7,1, 1,0,0, -1,0);
    add(0,0,0,0,1, 1,0,0, -1,0);
    // Saturation: 4 x 21 = 84 clips to 63; next result 4 x 1 clean.
    for (int i = 0; i < 3; i++) add(0,1,3,7,1, 1,0,1, -1,0);
    add(0,1,3,7,1, 0,1,0, 63,1);
    add(0,0,0,0,1, 1,0,0, -1,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,1, 1,0,1, -1,0);
    add(0,1,1,1,1, 0,1,0, 4,0);
    add(0,0,0,0,1, 1,0,0, -1,0);
    // Clear drops the partial sum and the pair offered alongside it.
    add(0,1,3,7,1, 1,0,1, -1,0);
    add(0,1,3,7,1, 1,0,1, -1,0);
    add(1,1,3,7,1, 1,0,0, -1,0);
    for (int i = 0; i < 3; i++) add(0,1,1,2,1, 1,0,1, -1,0);
    add(0,1,1,2,1, 0,1,0, 8,0);
    add(0,0,0,0,1, 1,0,0, -1,0);

    foreach (tbl[i]) begin
      do_cycle(tbl[i].clr, tbl[i].iv, tbl[i].m, tbl[i].q, tbl[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].e_vld));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].e_busy));
      if (tbl[i].e_sum >= 0) begin
        chk($sformatf("vec%0d_out_sum", i), int'(bus.out_sum), tbl[i].e_sum);
        chk($sformatf("vec%0d_out_overflow", i), int'(bus.out_overflow), int'(tbl[i].e_ovf));
      end
    end

    // Input gaps of 0..3 idle cycles between the pairs.
    for (int i = 0; i < 4; i++) begin
      int gap;
      do_cycle(0, 1, gm[i], gq[i], 1);
      if (i < 3) begin
        chk("gap_busy_after_accept", int'(bus.busy), 1);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          do_cycle(0, 0, 0, 0, 1);
          chk("gap_busy_idle", int'(bus.busy), 1);
        end
      end
    end
    chk("gap_out_valid", int'(bus.out_valid), 1);
    chk("gap_out_sum", int'(bus.out_sum), 23);
    chk("gap_busy_at_result", int'(bus.busy), 0);
    do_cycle(0, 0, 0, 0, 1);

    // Asynchronous reset while a result is held.
    for (int i = 0; i < 4; i++) do_cycle(0, 1, gm[i], gq[i], 0);
    chk("pre_reset_out_valid", int'(bus.out_valid), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_out_sum", int'(bus.out_sum), 0);
    chk("async_rst_out_overflow", int'(bus.out_overflow), 0);
    chk("async_rst_in_ready", int'(bus.in_ready), 1);
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Asynchronous reset mid-accumulation.
    do_cycle(0, 1, 3, 7, 1);
    do_cycle(0, 1, 2, 2, 1);
    chk("pre_reset_busy", int'(bus.busy), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_in_ready_accum", int'(bus.in_ready), 1);
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    do_cycle(0, 0, 0, 0, 1);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_in_ready", int'(bus.in_ready), 1);

    // LENGTH=1 instance: every accept goes straight to HOLD.
    chk("len1_in_ready", int'(bus1.in_ready), 1);
    bus1.in_valid = 1'b1; bus1.m = 2'd3; bus1.q = 3'd7; bus1.out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("len1_out_valid", int'(bus1.out_valid), 1);
    chk("len1_out_sum", int'(bus1.out_sum), 21);
    chk("len1_out_overflow", int'(bus1.out_overflow), 0);
    chk("len1_in_ready_hold", int'(bus1.in_ready), 0);
    chk("len1_busy", int'(bus1.busy), 0);
    bus1.m = 2'd2; bus1.q = 3'd2; bus1.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("len1_release_valid", int'(bus1.out_valid), 0);
    chk("len1_release_in_ready", int'(bus1.in_ready), 1);
    bus1.out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("len1_second_valid", int'(bus1.out_valid), 1);
    chk("len1_second_sum", int'(bus1.out_sum), 4);
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("len1_final_valid", int'(bus1.out_valid), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bit clr;
      bit iv;
      bit ordy;
      clr  = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      do_cycle(clr, iv, $urandom_range(0, 3), $urandom_range(0, 7), ordy);
    end
    do_cycle(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
